trng_key_buffer: RTL and testbench
==================================

// Module: trng_key_buffer
// PURPOSE
//  Buffers words from the TRNG core (key_ready/out_key/ack_read handshake) into a first-word-fall-through FIFO.
//  Sits between the core and the data register file, so bus reads never stall the core.
//  Runs an online repetition-count health test on accepted words.
//  Raises a level interrupt when data is available or the health test fails.
// PARAMETERS
//  N_BITS_KEY  32  width of one key word
//  DEPTH       4   FIFO entries; power of two, >=2
//  REP_LIMIT   3   identical consecutive accepted words that trip health fail; >=2
//  THRESHOLD   1   count_o level (1..DEPTH) at which intr_o asserts
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              reset: asynchronous, active-high
//  key_ready_i    in   1              core holds a valid word; level, held until acked
//  key_i          in   N_BITS_KEY     core word; stable while key_ready_i=1
//  ack_read_o     out  1              one-cycle registered pulse: word taken
//  rd_req_i       in   1              pop head entry (register-file read strobe)
//  rd_data_o      out  N_BITS_KEY     FIFO head (FWFT); 0 when empty
//  rd_valid_o     out  1              FIFO not empty
//  full_o         out  1              count_o==DEPTH
//  count_o        out  $clog2(DEPTH+1) occupancy
//  underflow_o    out  1              sticky: rd_req_i seen while empty
//  clear_i        in   1              synchronous flush; clears all sticky flags
//  health_fail_o  out  1              sticky repetition-count failure
//  intr_o         out  1              (count_o>=THRESHOLD) | health_fail_o
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; FSM=IDLE; repetition counter=0; last-word register=0.
//  - FSM IDLE:
//      key_ready_i=1 & !full & !health_fail at a clock edge -> key_i written to tail on that edge.
//      ack_read_o=1 for the next cycle; go to WAIT_DROP.
//  - FSM WAIT_DROP: accept nothing; return to IDLE on the first edge that samples key_ready_i=0.
//      Guarantees exactly one capture per core word.
//  - Full: FSM stays IDLE and no ack is issued; the core stalls (backpressure); no word is lost.
//      full is evaluated before a same-cycle pop.
//  - Pop: rd_req_i=1 & rd_valid_o=1 -> head advances on the edge; rd_data_o shows the new head next cycle.
//      rd_req_i on empty -> no pointer change; underflow_o=1 (sticky).
//  - Push and pop in the same cycle: both occur; count_o unchanged.
//  - Pointers: log2(DEPTH) bits; wrap modulo DEPTH; count_o is held separately.
//  - Latency: key_ready_i sampled at edge N -> rd_valid_o=1 and ack_read_o=1 during cycle N+1.
//  - clear_i: pointers, count, sticky flags and repetition counter -> 0; FSM -> WAIT_DROP.
//      No ack is issued; the core's pending word is accepted only after key_ready_i has dropped.
//      clear_i has priority over same-cycle push and pop.
//  - rst_i mid-handshake: everything is cleared immediately; a pending ack pulse is cancelled.
//  - intr_o: combinational from registered state; no extra delay.
// CONFIGURATION
//  TRNG_HEALTH_TEST_EN defined:
//   - each accepted word is compared with the previously accepted word;
//     equal -> rep_cnt+1 (saturating), else rep_cnt=1.
//   - rep_cnt reaching REP_LIMIT: the failing word is not stored; the FIFO is flushed on that edge;
//     health_fail_o=1 (sticky).
//   - while failed, no ack is issued and no word is captured, until clear_i.
//   - the failing word is still acked, so the core is not left hanging.
//  TRNG_HEALTH_TEST_EN undefined:
//   - no compare logic; health_fail_o tied to 0; all accepted words are stored.
// TESTING
//  1. Reset, core presents 0xA5A5_0001 and keeps key_ready_i high for 5 cycles
//     -> exactly one ack_read_o pulse, count_o=1, rd_data_o=0xA5A5_0001, intr_o=1.
//  2. Push DEPTH=4 distinct words, present a 5th -> full_o=1, no 5th ack.
//     One pop -> 5th word acked next free cycle; pop order matches push order.
//  3. Simultaneous pop and push at count_o=2 -> count_o stays 2; pointer wrap after 9 total pushes is correct.
//  4. rd_req_i on empty FIFO -> count_o stays 0, underflow_o=1; clear_i -> underflow_o=0.
//  5. (HEALTH_EN) three consecutive words 0x1234_5678
//     -> third acked but dropped, count_o=0, health_fail_o=1, intr_o=1.
//     Further words not acked until clear_i.
//  6. Assert rst_i in the cycle after capture (ack pending)
//     -> ack_read_o=0 immediately, count_o=0, all flags 0.

Source files
------------

// File: rtl/trng_key_buffer.sv
// -----------------------------------------------------------------------------
// trng_key_buffer
// Decouples the TRNG core from the data register file. Words offered by the
// core on the key_ready_i/key_i/ack_read_o handshake are captured into a
// first-word-fall-through FIFO, so register-file reads never stall the core.
// An optional online repetition-count health test watches the accepted words.
//
// Compile-time option:
//   TRNG_HEALTH_TEST_EN  enables the repetition-count health test. When it is
//                        not defined, health_fail_o is tied to 0 and every
//                        accepted word is stored.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous, active-high reset
//   key_ready_i    core holds a valid word (level, held until acked)
//   key_i          core word, stable while key_ready_i is high
//   ack_read_o     one-cycle registered pulse: word taken
//   rd_req_i       pop the head entry
//   rd_data_o      FIFO head, 0 when empty
//   rd_valid_o     FIFO not empty
//   full_o         FIFO holds DEPTH words
//   count_o        occupancy
//   underflow_o    sticky: pop requested while empty
//   clear_i        synchronous flush, also clears sticky flags
//   health_fail_o  sticky repetition-count failure
//   intr_o         level interrupt: occupancy at threshold or health failure
// -----------------------------------------------------------------------------
module trng_key_buffer #(
    parameter int N_BITS_KEY = 32,
    parameter int DEPTH      = 4,
    parameter int REP_LIMIT  = 3,
    parameter int THRESHOLD  = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       key_ready_i,
    input  logic [N_BITS_KEY-1:0]      key_i,
    output logic                       ack_read_o,
    input  logic                       rd_req_i,
    output logic [N_BITS_KEY-1:0]      rd_data_o,
    output logic                       rd_valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       underflow_o,
    input  logic                       clear_i,
    output logic                       health_fail_o,
    output logic                       intr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESHOLD);

    typedef enum logic {
        IDLE,
        WAIT_DROP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic                  store;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic                  ack_q;
    logic                  underflow_q;
    logic                  health_fail_q;
    logic                  health_trip;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [N_BITS_KEY-1:0] mem [DEPTH];

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign pop   = rd_req_i && !empty;
    // A word that trips the health test is still acked but never written.
    assign store = accept && !health_trip;

    // Handshake state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One capture per core word: after a capture we wait for key_ready_i to
    // drop before listening again. A flush also forces that wait, so a word
    // still pending across a clear is only taken once the core re-offers it.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_ready_i && !full && !health_fail_q) begin
                    accept  = 1'b1;
                    state_d = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!key_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            accept  = 1'b0;
            state_d = WAIT_DROP;
        end
    end

    // Ack pulse follows the capture edge by one cycle; reset cancels it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= accept;
        end
    end

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_C = RW'(REP_LIMIT);

    logic [RW-1:0]         rep_q;
    logic [RW-1:0]         rep_d;
    logic [N_BITS_KEY-1:0] last_q;

    // Run length of identical accepted words, saturating at the limit.
    always_comb begin
        rep_d = RW'(1);
        if (key_i == last_q) begin
            rep_d = (rep_q >= REP_C) ? rep_q : rep_q + 1'b1;
        end
        health_trip = accept && (rep_d >= REP_C);
    end

    // The last word is kept across a clear so the run restarts at one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep_q         <= '0;
            last_q        <= '0;
            health_fail_q <= 1'b0;
        end else if (clear_i) begin
            rep_q         <= '0;
            health_fail_q <= 1'b0;
        end else if (accept) begin
            rep_q  <= rep_d;
            last_q <= key_i;
            if (health_trip) begin
                health_fail_q <= 1'b1;
            end
        end
    end
`else
    assign health_trip   = 1'b0;
    assign health_fail_q = 1'b0;
`endif

    // FIFO control. Clear beats everything; a health trip flushes the
    // stored words on the same edge it is detected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (rd_req_i && empty) begin
                underflow_q <= 1'b1;
            end
            if (health_trip) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (store) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                unique case ({store, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage array needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem[wr_ptr_q] <= key_i;
        end
    end

    assign ack_read_o    = ack_q;
    assign rd_data_o     = empty ? '0 : mem[rd_ptr_q];
    assign rd_valid_o    = !empty;
    assign full_o        = full;
    assign count_o       = count_q;
    assign underflow_o   = underflow_q;
    assign health_fail_o = health_fail_q;
    assign intr_o        = (count_q >= THRESH_C) || health_fail_q;

endmodule

// File: tb/tb_trng_key_buffer.sv
// -----------------------------------------------------------------------------
// tb_trng_key_buffer
// Self-checking bench for trng_key_buffer. A queue-based reference model of
// the buffer tracks every cycle; directed tables and hand-written sequences
// cover the handshake, backpressure, wrap, underflow, clear and reset cases,
// followed by randomized core/reader traffic.
// -----------------------------------------------------------------------------
module tb_trng_key_buffer;

    localparam int N_BITS_KEY = 32;
    localparam int DEPTH      = 4;
    localparam int REP_LIMIT  = 3;
    localparam int THRESHOLD  = 1;
    localparam int CW         = $clog2(DEPTH + 1);

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  key_ready_i;
    logic [N_BITS_KEY-1:0] key_i;
    logic                  ack_read_o;
    logic                  rd_req_i;
    logic [N_BITS_KEY-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic [CW-1:0]         count_o;
    logic                  underflow_o;
    logic                  clear_i;
    logic                  health_fail_o;
    logic                  intr_o;

    int tests_run = 0;
    int tests_failed = 0;

    trng_key_buffer #(
        .N_BITS_KEY(N_BITS_KEY),
        .DEPTH     (DEPTH),
        .REP_LIMIT (REP_LIMIT),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .key_ready_i  (key_ready_i),
        .key_i        (key_i),
        .ack_read_o   (ack_read_o),
        .rd_req_i     (rd_req_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .underflow_o  (underflow_o),
        .clear_i      (clear_i),
        .health_fail_o(health_fail_o),
        .intr_o       (intr_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: stored words in order, whether a capture is
    // waiting for the core to drop its request, and the visible flags.
    logic [N_BITS_KEY-1:0] m_q[$];
    bit                    m_busy;
    bit                    m_ack;
    bit                    m_uf;
    bit                    m_fail;
    int                    m_rep;
    logic [N_BITS_KEY-1:0] m_last;

    typedef struct {
        logic        kr;
        logic [31:0] key;
        logic        rd;
        logic        clr;
        logic        exp_ack;
        int          exp_count;
        logic [31:0] exp_data;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[10];

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_ack  = 0;
        m_uf   = 0;
        m_fail = 0;
        m_rep  = 0;
        m_last = '0;
    endtask

    // One clock edge of the buffer's documented behaviour.
    task automatic model_step(input bit kr, input logic [31:0] key, input bit rd, input bit clr);
        bit take;
        bit trip;
        bit popit;
        int r;
        if (clr) begin
            m_q.delete();
            m_uf   = 0;
            m_fail = 0;
            m_rep  = 0;
            m_busy = 1;
            m_ack  = 0;
            return;
        end
        take  = !m_busy && kr && (m_q.size() < DEPTH) && !m_fail;
        popit = rd && (m_q.size() > 0);
        if (rd && m_q.size() == 0) m_uf = 1;
        if (m_busy && !kr) m_busy = 0;
        trip = 0;
        if (take) begin
            m_busy = 1;
`ifdef TRNG_HEALTH_TEST_EN
            if (key == m_last) r = (m_rep + 1 > REP_LIMIT) ? REP_LIMIT : m_rep + 1;
            else r = 1;
            m_rep  = r;
            m_last = key;
            trip   = (r >= REP_LIMIT);
`else
            r = 0;
`endif
        end
        m_ack = take;
        if (trip) begin
            m_q.delete();
            m_fail = 1;
        end else begin
            if (popit) void'(m_q.pop_front());
            if (take) m_q.push_back(key);
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 32'h0;
        check_output("count", 32'(count_o), 32'(m_q.size()));
        check_output("rd_valid", 32'(rd_valid_o), 32'(m_q.size() > 0));
        check_output("rd_data", rd_data_o, head);
        check_output("full", 32'(full_o), 32'(m_q.size() == DEPTH));
        check_output("ack", 32'(ack_read_o), 32'(m_ack));
        check_output("underflow", 32'(underflow_o), 32'(m_uf));
        check_output("health_fail", 32'(health_fail_o), 32'(m_fail));
        check_output("intr", 32'(intr_o), 32'((m_q.size() >= THRESHOLD) || m_fail));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // compare just after the edge.
    task automatic apply_stimulus(input bit kr, input logic [31:0] key, input bit rd, input bit clr);
        key_ready_i = kr;
        key_i       = key;
        rd_req_i    = rd;
        clear_i     = clr;
        @(posedge clk_i);
        model_step(kr, key, rd, clr);
        #1;
        check_model();
    endtask

    task automatic push_word(input logic [31:0] w);
        apply_stimulus(1, w, 0, 0);
        check_output("push_ack", 32'(ack_read_o), 32'h1);
        apply_stimulus(0, w, 0, 0);
    endtask

    initial begin
        bit          kr;
        logic [31:0] key;
        bit          rd;
        bit          clr;

        rst_i       = 1'b1;
        key_ready_i = 1'b0;
        key_i       = '0;
        rd_req_i    = 1'b0;
        clear_i     = 1'b0;
        model_reset();

        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1, 32'hA5A5_0001, 1'b0};
        vecs[1] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
        vecs[2] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
        vecs[3] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
        vecs[4] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0,         1'b1};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 0, 32'h0,         1'b0};
        vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 0, 32'h0,         1'b0};

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check_model();
        check_output("reset_intr", 32'(intr_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single capture under a held request, then pop, underflow, clear.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].kr, vecs[i].key, vecs[i].rd, vecs[i].clr);
            check_output($sformatf("vec%0d_ack", i), 32'(ack_read_o), 32'(vecs[i].exp_ack));
            check_output($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d_data", i), rd_data_o, vecs[i].exp_data);
            check_output($sformatf("vec%0d_uf", i), 32'(underflow_o), 32'(vecs[i].exp_uf));
        end

        // Fill to full, stall a fifth word, then release it with one pop.
        for (int i = 0; i < DEPTH; i++) push_word(32'hB0B0_0002 + 32'(i));
        check_output("full_after_fill", 32'(full_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 32'hB0B0_0006, 0, 0);
            check_output("stalled_ack", 32'(ack_read_o), 32'h0);
        end
        apply_stimulus(1, 32'hB0B0_0006, 1, 0);
        check_output("pop_while_full_count", 32'(count_o), 32'd3);
        check_output("pop_while_full_ack", 32'(ack_read_o), 32'h0);
        apply_stimulus(1, 32'hB0B0_0006, 0, 0);
        check_output("fifth_ack", 32'(ack_read_o), 32'h1);
        check_output("fifth_count", 32'(count_o), 32'd4);
        apply_stimulus(0, 32'h0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check_output("pop_order", rd_data_o, 32'hB0B0_0003 + 32'(i));
            apply_stimulus(0, 32'h0, 1, 0);
        end

        // Simultaneous push and pop at two entries, crossing the wrap point.
        push_word(32'hC1C1_0007);
        push_word(32'hC1C1_0008);
        apply_stimulus(1, 32'hC1C1_0009, 1, 0);
        check_output("pushpop_count", 32'(count_o), 32'd2);
        apply_stimulus(0, 32'h0, 0, 0);
        check_output("wrap_head0", rd_data_o, 32'hC1C1_0008);
        apply_stimulus(0, 32'h0, 1, 0);
        check_output("wrap_head1", rd_data_o, 32'hC1C1_0009);
        apply_stimulus(0, 32'h0, 1, 0);

`ifdef TRNG_HEALTH_TEST_EN
        // Three identical words: third acked but dropped, FIFO flushed.
        push_word(32'h1234_5678);
        push_word(32'h1234_5678);
        apply_stimulus(1, 32'h1234_5678, 0, 0);
        check_output("hf_ack", 32'(ack_read_o), 32'h1);
        check_output("hf_count", 32'(count_o), 32'd0);
        check_output("hf_flag", 32'(health_fail_o), 32'h1);
        check_output("hf_intr", 32'(intr_o), 32'h1);
        apply_stimulus(0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 32'hDEAD_0001, 0, 0);
            check_output("hf_no_ack", 32'(ack_read_o), 32'h0);
        end
        apply_stimulus(1, 32'hDEAD_0001, 0, 1);
        apply_stimulus(0, 32'h0, 0, 0);
        check_output("hf_cleared", 32'(health_fail_o), 32'h0);
`endif

        // Reset while the ack pulse is showing.
        apply_stimulus(1, 32'hE0E0_000A, 0, 0);
        check_output("pre_reset_ack", 32'(ack_read_o), 32'h1);
        key_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_model();
        check_output("reset_ack_cancel", 32'(ack_read_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        apply_stimulus(0, 32'h0, 0, 0);

        // Randomized traffic: a core that holds each word until acked
        // (occasionally withdrawing it), a random reader and rare clears.
        kr  = 0;
        key = '0;
        for (int c = 0; c < 600; c++) begin
            if (!kr) begin
                if ($urandom_range(0, 2) == 0) begin
                    kr  = 1;
                    key = 32'hC0DE_0000 | 32'($urandom_range(0, 3));
                end
            end else if (m_ack || $urandom_range(0, 7) == 0) begin
                kr = 0;
            end
            rd  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 39) == 0);
            apply_stimulus(kr, key, rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
